// File: rtl/lever_sim_multi_if.sv
// Bus bundle for lever_sim_multi: per-tick lever/gravity/end-stop inputs and
// the step outputs handed to the stepper drivers.
interface lever_sim_multi_if #(
    parameter int CHANNELS = 2,
    parameter int INT_W    = 16,
    parameter int FRAC_W   = 16
);
    logic [CHANNELS*(INT_W+FRAC_W)-1:0] acc_in;
    logic [INT_W+FRAC_W-1:0]            gravity;
    logic [CHANNELS-1:0]                calib;
    logic [CHANNELS-1:0]                end_lo;
    logic [CHANNELS-1:0]                end_hi;
    logic [CHANNELS*INT_W-1:0]          delta_steps;
    logic [CHANNELS*INT_W-1:0]          current_pos;
    logic                               out_valid;
    logic                               tick;

    modport master (
        output acc_in, gravity, calib, end_lo, end_hi,
        input  delta_steps, current_pos, out_valid, tick
    );

    modport slave (
        input  acc_in, gravity, calib, end_lo, end_hi,
        output delta_steps, current_pos, out_valid, tick
    );
endinterface

// File: rtl/lever_sim_multi.sv
// Multi-channel lever simulator: per tick, integrates acceleration into velocity
// and position for each channel, one channel per clock. Optional viscous damping
// is enabled by defining LEVER_SIM_DAMPING_EN.
module lever_sim_multi #(
    parameter int CHANNELS  = 2,
    parameter int INT_W     = 16,
    parameter int FRAC_W    = 16,
    parameter int VEXT_W    = 8,
    parameter int TICK_DIV  = 500000,
    parameter int ACC_SHIFT = 0,
    parameter int VEL_SHIFT = 0,
    parameter logic [INT_W+FRAC_W-1:0] VMAX = 32'h0008_0000,
    parameter int POS_MAX   = 1599,
    parameter int CAL_STEP  = 1
`ifdef LEVER_SIM_DAMPING_EN
    , parameter int DAMP_SHIFT = 6
`endif
) (
    input  logic             clock,
    input  logic             reset,
    lever_sim_multi_if.slave bus
);
    localparam int AW    = INT_W + FRAC_W;
    localparam int VW    = INT_W + VEXT_W + FRAC_W;
    localparam int PW    = VW + 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PROC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic signed [AW-1:0] A_MAX     = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] A_MIN     = -A_MAX;
    localparam logic signed [VW-1:0] V_MAX     = $signed({{VEXT_W{1'b0}}, VMAX});
    localparam logic signed [VW-1:0] V_MIN     = -V_MAX;
    localparam logic signed [AW-1:0] P_MAX_FIX = {INT_W'(POS_MAX), {FRAC_W{1'b0}}};

    if (TICK_DIV < CHANNELS + 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least CHANNELS+2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             tick;

    logic [CHANNELS-1:0][AW-1:0] snap_acc_q, snap_acc_d;
    logic [AW-1:0]               snap_grav_q, snap_grav_d;
    logic [CHANNELS-1:0]         snap_cal_q, snap_cal_d;
    logic [CHANNELS-1:0]         snap_lo_q, snap_lo_d;
    logic [CHANNELS-1:0]         snap_hi_q, snap_hi_d;

    logic [CHANNELS-1:0][VW-1:0]    v_q, v_d;
    logic [CHANNELS-1:0][AW-1:0]    p_q, p_d;
    logic [CHANNELS-1:0][INT_W-1:0] stage_pos_q, stage_pos_d;
    logic [CHANNELS-1:0][INT_W-1:0] stage_dl_q, stage_dl_d;
    logic [CHANNELS-1:0][INT_W-1:0] pos_q, pos_d;
    logic [CHANNELS-1:0][INT_W-1:0] dl_q, dl_d;
    logic                           out_valid_q, out_valid_d;

    logic signed [AW:0]         acc_sum;
    logic signed [AW-1:0]       a_sat;
    logic signed [VW-1:0]       a_ext, v_cur, v_damp, v_new, v_fin;
    logic signed [VW:0]         v_sum;
    logic signed [PW-1:0]       p_sum;
    logic signed [PW-FRAC_W-1:0] p_int;
    logic signed [AW-1:0]       p_new;
    logic [INT_W-1:0]           pos_new, dl_new;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Datapath for the channel selected by ch_q, operating on the tick snapshot.
    always_comb begin
        acc_sum = (AW+1)'($signed(snap_acc_q[ch_q])) + (AW+1)'($signed(snap_grav_q));
        if (acc_sum > (AW+1)'(A_MAX))      a_sat = A_MAX;
        else if (acc_sum < (AW+1)'(A_MIN)) a_sat = A_MIN;
        else                               a_sat = acc_sum[AW-1:0];

        a_ext = VW'(a_sat >>> ACC_SHIFT);
        v_cur = $signed(v_q[ch_q]);
`ifdef LEVER_SIM_DAMPING_EN
        v_damp = (v_cur != '0) ? v_cur - (v_cur >>> DAMP_SHIFT) : v_cur;
`else
        v_damp = v_cur;
`endif
        v_sum = (VW+1)'(v_damp) + (VW+1)'(a_ext);
        if (v_sum > (VW+1)'(V_MAX))      v_new = V_MAX;
        else if (v_sum < (VW+1)'(V_MIN)) v_new = V_MIN;
        else                             v_new = v_sum[VW-1:0];

        p_sum = PW'($signed(p_q[ch_q])) + PW'(v_new >>> VEL_SHIFT);
        p_int = p_sum[PW-1:FRAC_W];
        v_fin = v_new;
        p_new = p_sum[AW-1:0];

        if (snap_cal_q[ch_q]) begin
            v_fin = '0;
            if (snap_lo_q[ch_q])      p_new = '0;
            else if (snap_hi_q[ch_q]) p_new = P_MAX_FIX;
            else                      p_new = $signed(p_q[ch_q]);
        end else if (p_sum[PW-1]) begin
            v_fin = '0;
            p_new = '0;
        end else if (p_int > (PW-FRAC_W)'(POS_MAX)) begin
            v_fin = '0;
            p_new = P_MAX_FIX;
        end

        pos_new = p_new[AW-1:FRAC_W];
        dl_new  = snap_cal_q[ch_q] ? INT_W'(CAL_STEP) : pos_new - pos_q[ch_q];
    end

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
        state_d     = state_q;
        ch_d        = ch_q;
        snap_acc_d  = snap_acc_q;
        snap_grav_d = snap_grav_q;
        snap_cal_d  = snap_cal_q;
        snap_lo_d   = snap_lo_q;
        snap_hi_d   = snap_hi_q;
        v_d         = v_q;
        p_d         = p_q;
        stage_pos_d = stage_pos_q;
        stage_dl_d  = stage_dl_q;
        pos_d       = pos_q;
        dl_d        = dl_q;
        out_valid_d = 1'b0;

        if (tick) begin
            snap_acc_d  = bus.acc_in;
            snap_grav_d = bus.gravity;
            snap_cal_d  = bus.calib;
            snap_lo_d   = bus.end_lo;
            snap_hi_d   = bus.end_hi;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = PROC;
                    ch_d    = '0;
                end
            end
            PROC: begin
                v_d[ch_q]         = v_fin;
                p_d[ch_q]         = p_new;
                stage_pos_d[ch_q] = pos_new;
                stage_dl_d[ch_q]  = dl_new;
                // Outputs load on the edge into DONE so they appear together with out_valid.
                if (ch_q == CH_W'(CHANNELS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    pos_d       = stage_pos_d;
                    dl_d        = stage_dl_d;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            state_q     <= IDLE;
            ch_q        <= '0;
            snap_acc_q  <= '0;
            snap_grav_q <= '0;
            snap_cal_q  <= '0;
            snap_lo_q   <= '0;
            snap_hi_q   <= '0;
            v_q         <= '0;
            p_q         <= '0;
            stage_pos_q <= '0;
            stage_dl_q  <= '0;
            pos_q       <= '0;
            dl_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            snap_acc_q  <= snap_acc_d;
            snap_grav_q <= snap_grav_d;
            snap_cal_q  <= snap_cal_d;
            snap_lo_q   <= snap_lo_d;
            snap_hi_q   <= snap_hi_d;
            v_q         <= v_d;
            p_q         <= p_d;
            stage_pos_q <= stage_pos_d;
            stage_dl_q  <= stage_dl_d;
            pos_q       <= pos_d;
            dl_q        <= dl_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.tick        = tick;
    assign bus.out_valid   = out_valid_q;
    assign bus.current_pos = pos_q;
    assign bus.delta_steps = dl_q;
endmodule
